// File: rtl/ir_nec_rx_pkg.sv
// Shared NEC decoder definitions: FSM encoding, pulse-width windows in microseconds
// and the small combinational helpers used by the decoder.
package ir_nec_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEAD_L = 3'd1,
        ST_LEAD_H = 3'd2,
        ST_BIT_L  = 3'd3,
        ST_BIT_H  = 3'd4,
        ST_RPT_L  = 3'd5
    } state_t;

    localparam int unsigned LEAD_L_MIN_US = 32'd8000;
    localparam int unsigned LEAD_L_MAX_US = 32'd10000;
    localparam int unsigned LEAD_H_MIN_US = 32'd4000;
    localparam int unsigned LEAD_H_MAX_US = 32'd5000;
    localparam int unsigned RPT_H_MIN_US  = 32'd2000;
    localparam int unsigned RPT_H_MAX_US  = 32'd2500;
    localparam int unsigned BIT_MIN_US    = 32'd400;
    localparam int unsigned BIT_MAX_US    = 32'd700;
    localparam int unsigned ONE_MIN_US    = 32'd1400;
    localparam int unsigned ONE_MAX_US    = 32'd1900;

    function automatic logic in_win(input logic [15:0] v, input logic [15:0] lo,
                                    input logic [15:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Byte layout on the wire: addr, addr_n, cmd, cmd_n (LSB first).
    function automatic logic frame_ok(input logic [31:0] w, input logic chk_addr);
        return ((w[23:16] ^ w[31:24]) == 8'hFF) &&
               (!chk_addr || ((w[7:0] ^ w[15:8]) == 8'hFF));
    endfunction

endpackage

// File: rtl/ir_nec_rx_if.sv
// Decoder <-> SFR block connection: held frame bytes, status flags and read acknowledge.
interface ir_nec_rx_if;
    logic       rd_ack;
    logic       data_valid;
    logic [7:0] ir_addr;
    logic [7:0] ir_addr_n;
    logic [7:0] ir_cmd;
    logic       repeat_flag;
    logic       overrun;
    logic       frame_err;

    modport master (input rd_ack, output data_valid, ir_addr, ir_addr_n, ir_cmd,
                    repeat_flag, overrun, frame_err);
    modport slave  (output rd_ack, input data_valid, ir_addr, ir_addr_n, ir_cmd,
                    repeat_flag, overrun, frame_err);
endinterface

// File: rtl/ir_nec_rx_us_tick.sv
// Free-running prescaler: one-clock tick strobe every TICK_DIV clocks (1 us at 50 MHz).
module ir_us_tick #(
    parameter int unsigned TICK_DIV = 32'd50
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 32'd1);

    logic [CW-1:0] cnt_r;

    // Prescaler count 0..TICK_DIV-1 with registered strobe on the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            tick  <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + CW'(1);
            tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/ir_nec_rx.sv
// NEC IR frame decoder: measures mark/space widths on the synchronised receiver
// output and presents address/command bytes plus repeat/overrun/error status.
module ir_nec_rx
    import ir_nec_rx_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 32'd50,
    parameter bit          CHECK_ADDR = 1'b0,
    // Divides every timing window; 1 gives real NEC timing.
    parameter int unsigned WIN_DIV    = 32'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ir_rxd,
    ir_nec_rx_if.master     sfr
);
    localparam logic [15:0] LL_MIN  = 16'(LEAD_L_MIN_US / WIN_DIV);
    localparam logic [15:0] LL_MAX  = 16'(LEAD_L_MAX_US / WIN_DIV);
    localparam logic [15:0] LH_MIN  = 16'(LEAD_H_MIN_US / WIN_DIV);
    localparam logic [15:0] LH_MAX  = 16'(LEAD_H_MAX_US / WIN_DIV);
    localparam logic [15:0] RH_MIN  = 16'(RPT_H_MIN_US / WIN_DIV);
    localparam logic [15:0] RH_MAX  = 16'(RPT_H_MAX_US / WIN_DIV);
    localparam logic [15:0] B_MIN   = 16'(BIT_MIN_US / WIN_DIV);
    localparam logic [15:0] B_MAX   = 16'(BIT_MAX_US / WIN_DIV);
    localparam logic [15:0] O_MIN   = 16'(ONE_MIN_US / WIN_DIV);
    localparam logic [15:0] O_MAX   = 16'(ONE_MAX_US / WIN_DIV);

    logic        tick_s;
    logic        sync1_r, sync2_r, last_r;
    logic        fall_s, rise_s, edge_s;
    logic [15:0] cnt_r, max_s;
    state_t      state_r, state_s;
    logic [5:0]  bit_idx_r, bit_idx_s;
    logic [31:0] shreg_r, shreg_s, word_s;
    logic        zero_s, one_s, timeout_s, err_s, load_s, rpt_s;
    logic        data_valid_r, repeat_flag_r, overrun_r, frame_err_r, seen_valid_r;
    logic [7:0]  addr_r, addr_n_r, cmd_r;

    ir_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick_s));

    // Two-flop synchroniser plus previous level; idle-high so reset never fakes a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            last_r  <= 1'b1;
        end else begin
            sync1_r <= ir_rxd;
            sync2_r <= sync1_r;
            last_r  <= sync2_r;
        end
    end

    assign fall_s = last_r & ~sync2_r;
    assign rise_s = ~last_r & sync2_r;
    assign edge_s = fall_s | rise_s;

    // Pulse-width counter in ticks: cleared on every edge, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (edge_s) begin
            cnt_r <= 16'd0;
        end else if (tick_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign zero_s    = in_win(cnt_r, B_MIN, B_MAX);
    assign one_s     = in_win(cnt_r, O_MIN, O_MAX);
    assign word_s    = {one_s, shreg_r[31:1]};
    assign timeout_s = (state_r != ST_IDLE) && (cnt_r > max_s);

    // Longest legal duration of the level the current state is measuring.
    always_comb begin
        max_s = 16'hFFFF;
        case (state_r)
            ST_LEAD_L: max_s = LL_MAX;
            ST_LEAD_H: max_s = LH_MAX;
            ST_BIT_L:  max_s = B_MAX;
            ST_BIT_H:  max_s = O_MAX;
            ST_RPT_L:  max_s = B_MAX;
            default:   max_s = 16'hFFFF;
        endcase
    end

    // FSM state, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_idx_r <= 6'd0;
            shreg_r   <= 32'd0;
        end else begin
            state_r   <= state_s;
            bit_idx_r <= bit_idx_s;
            shreg_r   <= shreg_s;
        end
    end

    // Next-state decode; any out-of-window edge or overlong level aborts to IDLE.
    always_comb begin
        state_s   = state_r;
        bit_idx_s = bit_idx_r;
        shreg_s   = shreg_r;
        err_s     = 1'b0;
        load_s    = 1'b0;
        rpt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_s = ST_LEAD_L;
                else        state_s = ST_IDLE;
            end
            ST_LEAD_L: begin
                if (rise_s && in_win(cnt_r, LL_MIN, LL_MAX)) begin
                    state_s = ST_LEAD_H;
                end else if (edge_s || timeout_s) begin
                    err_s = 1'b1; state_s = ST_IDLE;
                end else begin
                    state_s = ST_LEAD_L;
                end
            end
            ST_LEAD_H: begin
                if (fall_s && in_win(cnt_r, LH_MIN, LH_MAX)) begin
                    state_s = ST_BIT_L; bit_idx_s = 6'd0; shreg_s = 32'd0;
                end else if (fall_s && in_win(cnt_r, RH_MIN, RH_MAX)) begin
                    state_s = ST_RPT_L;
                end else if (edge_s || timeout_s) begin
                    err_s = 1'b1; state_s = ST_IDLE;
                end else begin
                    state_s = ST_LEAD_H;
                end
            end
            ST_BIT_L: begin
                if (rise_s && zero_s) begin
                    state_s = (bit_idx_r == 6'd32) ? ST_IDLE : ST_BIT_H;
                end else if (edge_s || timeout_s) begin
                    err_s = 1'b1; state_s = ST_IDLE;
                end else begin
                    state_s = ST_BIT_L;
                end
            end
            ST_BIT_H: begin
                if (fall_s && (zero_s || one_s)) begin
                    shreg_s   = word_s;
                    bit_idx_s = bit_idx_r + 6'd1;
                    state_s   = ST_BIT_L;
                    if (bit_idx_r == 6'd31) begin
                        if (frame_ok(word_s, CHECK_ADDR)) begin
                            load_s = 1'b1;
                        end else begin
                            err_s = 1'b1; state_s = ST_IDLE;
                        end
                    end else begin
                        load_s = 1'b0;
                    end
                end else if (edge_s || timeout_s) begin
                    err_s = 1'b1; state_s = ST_IDLE;
                end else begin
                    state_s = ST_BIT_H;
                end
            end
            ST_RPT_L: begin
                if (rise_s && zero_s) begin
                    rpt_s = 1'b1; state_s = ST_IDLE;
                end else if (edge_s || timeout_s) begin
                    err_s = 1'b1; state_s = ST_IDLE;
                end else begin
                    state_s = ST_RPT_L;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Holding registers and status flags seen by the SFR side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r        <= 8'd0;
            addr_n_r      <= 8'd0;
            cmd_r         <= 8'd0;
            data_valid_r  <= 1'b0;
            overrun_r     <= 1'b0;
            repeat_flag_r <= 1'b0;
            frame_err_r   <= 1'b0;
            seen_valid_r  <= 1'b0;
        end else begin
            frame_err_r <= err_s;
            if (load_s) begin
                addr_r       <= word_s[7:0];
                addr_n_r     <= word_s[15:8];
                cmd_r        <= word_s[23:16];
                data_valid_r <= 1'b1;
                seen_valid_r <= 1'b1;
                // A read landing on the completion cycle consumes the old data cleanly.
                overrun_r    <= sfr.rd_ack ? 1'b0 : (overrun_r | data_valid_r);
            end else if (sfr.rd_ack) begin
                data_valid_r <= 1'b0;
                overrun_r    <= 1'b0;
            end
            if (rpt_s && seen_valid_r) begin
                repeat_flag_r <= 1'b1;
            end else if (sfr.rd_ack) begin
                repeat_flag_r <= 1'b0;
            end
        end
    end

    assign sfr.data_valid  = data_valid_r;
    assign sfr.ir_addr     = addr_r;
    assign sfr.ir_addr_n   = addr_n_r;
    assign sfr.ir_cmd      = cmd_r;
    assign sfr.repeat_flag = repeat_flag_r;
    assign sfr.overrun     = overrun_r;
    assign sfr.frame_err   = frame_err_r;
endmodule
